// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, per-cycle reject pulses and registered read data.
// A write into a full FIFO is accepted when a read is requested in the same cycle.
module sync_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  fifo_wr_en,
  input  logic [FIFO_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_rd_en,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_wr_err,
  output logic                  fifo_rd_err,
  output logic [FIFO_WIDTH-1:0] fifo_rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_wr_err;
  logic                  r_rd_err;
  logic [FIFO_WIDTH-1:0] r_rd_data;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CW-1:0]         w_count_nxt;

  assign w_wr_ok = fifo_wr_en & (~r_full | fifo_rd_en);
  assign w_rd_ok = fifo_rd_en & ~r_empty;

  // Next occupancy from the accepted operations of this cycle.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array is deliberately not reset; pointers make stale words unreachable.
  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= fifo_wr_data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_wr_err  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty  <= (w_count_nxt == CW'(0));
      r_wr_err <= fifo_wr_en & ~w_wr_ok;
      r_rd_err <= fifo_rd_en & ~w_rd_ok;
    end
  end

  assign fifo_full    = r_full;
  assign fifo_empty   = r_empty;
  assign fifo_wr_err  = r_wr_err;
  assign fifo_rd_err  = r_rd_err;
  assign fifo_rd_data = r_rd_data;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=8, DEPTH=16).
module tb_sync_fifo;

  logic       CLK;
  logic       nRST;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_wr_err;
  logic       fifo_rd_err;
  logic [7:0] fifo_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_wr_err  (fifo_wr_err),
    .fifo_rd_err  (fifo_rd_err),
    .fifo_rd_data (fifo_rd_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests, sample 1 time unit after the edge, then idle the inputs.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    fifo_wr_en   = we;
    fifo_wr_data = wd;
    fifo_rd_en   = re;
    @(posedge CLK);
    #1;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    fifo_rd_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},  {31'd0, fifo_empty},  32'd1);
    check({tag, "_full"},   {31'd0, fifo_full},   32'd0);
    check({tag, "_wr_err"}, {31'd0, fifo_wr_err}, 32'd0);
    check({tag, "_rd_err"}, {31'd0, fifo_rd_err}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, fifo_rd_data}, 32'h00);
  endtask

  initial begin
    nRST         = 1'b1;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    fifo_rd_en   = 1'b0;

    // Asynchronous reset pulse between clock edges.
    #2 nRST = 1'b0;
    #1 check_reset_outputs("rst");
    #1 nRST = 1'b1;

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      check("fill_empty", {31'd0, fifo_empty}, 32'd0);
      check("fill_full",  {31'd0, fifo_full},  (i == 15) ? 32'd1 : 32'd0);
    end

    // Overflow write.
    cycle(1'b1, 8'hAA, 1'b0);
    check("ovf_wr_err", {31'd0, fifo_wr_err}, 32'd1);
    check("ovf_full",   {31'd0, fifo_full},   32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    check("ovf_wr_err_clr", {31'd0, fifo_wr_err}, 32'd0);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_data",   {24'd0, fifo_rd_data}, 32'(i));
      check("drain_empty",  {31'd0, fifo_empty},   (i == 15) ? 32'd1 : 32'd0);
      check("drain_rd_err", {31'd0, fifo_rd_err},  32'd0);
    end

    // Underflow read.
    cycle(1'b0, 8'h00, 1'b1);
    check("udf_rd_err", {31'd0, fifo_rd_err},  32'd1);
    check("udf_data",   {24'd0, fifo_rd_data}, 32'h0F);
    cycle(1'b0, 8'h00, 1'b0);
    check("udf_rd_err_clr", {31'd0, fifo_rd_err},  32'd0);
    check("udf_data_hold",  {24'd0, fifo_rd_data}, 32'h0F);

    // Simultaneous write+read while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    check("sf_pre_full", {31'd0, fifo_full}, 32'd1);
    cycle(1'b1, 8'h55, 1'b1);
    check("sf_wr_err", {31'd0, fifo_wr_err},  32'd0);
    check("sf_full",   {31'd0, fifo_full},    32'd1);
    check("sf_data",   {24'd0, fifo_rd_data}, 32'h10);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("sf_drain", {24'd0, fifo_rd_data}, 32'(8'h10 + i));
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("sf_last",  {24'd0, fifo_rd_data}, 32'h55);
    check("sf_empty", {31'd0, fifo_empty},   32'd1);

    // Simultaneous write+read while empty.
    cycle(1'b1, 8'h33, 1'b1);
    check("se_rd_err", {31'd0, fifo_rd_err},  32'd1);
    check("se_empty",  {31'd0, fifo_empty},   32'd0);
    check("se_hold",   {24'd0, fifo_rd_data}, 32'h55);
    cycle(1'b0, 8'h00, 1'b1);
    check("se_data",   {24'd0, fifo_rd_data}, 32'h33);
    check("se_empty2", {31'd0, fifo_empty},   32'd1);
    check("se_rd_err2", {31'd0, fifo_rd_err}, 32'd0);

    // Pointer wrap with one entry in flight.
    cycle(1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h81 + i), 1'b1);
      check("wrap_data",  {24'd0, fifo_rd_data}, 32'(8'h80 + i));
      check("wrap_empty", {31'd0, fifo_empty},   32'd0);
      check("wrap_full",  {31'd0, fifo_full},    32'd0);
      check("wrap_errs",  {30'd0, fifo_wr_err, fifo_rd_err}, 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("wrap_last",  {24'd0, fifo_rd_data}, 32'hA8);
    check("wrap_empty_end", {31'd0, fifo_empty}, 32'd1);

    // Reset mid-operation with 5 entries stored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    check("mid_pre_empty", {31'd0, fifo_empty}, 32'd0);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("mid_rst");
    #2 nRST = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    check("mid_rd_err", {31'd0, fifo_rd_err}, 32'd1);
    check("mid_empty",  {31'd0, fifo_empty},  32'd1);
    cycle(1'b1, 8'h7E, 1'b0);
    check("mid_wr_empty", {31'd0, fifo_empty}, 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("mid_data",   {24'd0, fifo_rd_data}, 32'h7E);
    check("mid_empty2", {31'd0, fifo_empty},   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
